// File: rtl/systolic_ctrl_if.sv
// Control, buffer-read, array-feed and result bundle of the systolic sequencer.
// Pure wiring, no latency of its own.
// No backpressure anywhere: every strobe and result is unconditional.
interface systolic_ctrl_if #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int data_length = 8,
   parameter int acc_length  = 32,
   parameter int NV_W        = 16
);
   localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                          start;
   logic [NV_W-1:0]               cfg_n_vec;
   logic                          busy;
   logic                          done;
   logic                          w_rd_en;
   logic [AW-1:0]                 w_rd_addr;
   logic [COLS*data_length-1:0]   w_rd_data;
   logic                          img_rd_en;
   logic [NV_W-1:0]               img_rd_addr;
   logic [ROWS*data_length-1:0]   img_rd_data;
   logic [COLS-1:0]               arr_w_load;
   logic [COLS*data_length-1:0]   arr_w_data;
   logic [ROWS-1:0]               arr_i_load;
   logic [ROWS*data_length-1:0]   arr_i_data;
   logic [COLS*acc_length-1:0]    arr_acc;
   logic                          res_valid;
   logic [COLS*acc_length-1:0]    res_data;
   logic [NV_W-1:0]               res_idx;

   // sequencer side
   modport master (
      input  start, cfg_n_vec, w_rd_data, img_rd_data, arr_acc,
      output busy, done, w_rd_en, w_rd_addr, img_rd_en, img_rd_addr,
             arr_w_load, arr_w_data, arr_i_load, arr_i_data,
             res_valid, res_data, res_idx
   );

   // buffers / host / array side
   modport slave (
      output start, cfg_n_vec, w_rd_data, img_rd_data, arr_acc,
      input  busy, done, w_rd_en, w_rd_addr, img_rd_en, img_rd_addr,
             arr_w_load, arr_w_data, arr_i_load, arr_i_data,
             res_valid, res_data, res_idx
   );
endinterface

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: weight tile load, skewed image stream, result deskew.
// Job takes 2*ROWS+2 cycles (N=0) or 3*ROWS+COLS+2+N cycles from start to done.
// No backpressure: buffers answer in one cycle and results must be taken every res_valid cycle.
module systolic_ctrl #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int data_length = 8,
   parameter int acc_length  = 32,
   parameter int NV_W        = 16
) (
   input logic            clk,
   input logic            rst,
   systolic_ctrl_if.master bus
);
   localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DL = data_length;
   localparam int AL = acc_length;
   // arr_i_load[0] to aligned result valid
   localparam int TD = ROWS + COLS - 1;
   localparam logic [NV_W-1:0] ONE         = NV_W'(1);
   localparam logic [NV_W-1:0] W_LAST      = NV_W'(ROWS - 1);
   localparam logic [NV_W-1:0] SETTLE_LAST = NV_W'(ROWS);

   typedef enum logic [2:0] {
      S_IDLE, S_W_FEED, S_W_SETTLE, S_I_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [NV_W-1:0]   cnt_q, cnt_d;
   logic [NV_W-1:0]   n_q, n_d;
   logic [NV_W-1:0]   res_cnt_q, res_cnt_d;
   logic [NV_W-1:0]   img_rd_addr_q, img_rd_addr_d;
   logic [AW-1:0]     w_rd_addr_q, w_rd_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              w_rd_en_q, w_rd_en_d;
   logic              img_rd_en_q, img_rd_en_d;
   logic              i_vld_q, i_vld_d;
   logic [COLS-1:0]   arr_w_load_q, arr_w_load_d;
   logic [TD-1:0]     tok_q, tok_d;
   logic              res_valid;

   logic              i_ld  [ROWS];
   logic [DL-1:0]     i_dat [ROWS];
   logic [AL-1:0]     col_al [COLS];
   logic [ROWS-1:0]   i_load_vec;
   logic [ROWS*DL-1:0] i_dat_vec;
   logic [COLS*AL-1:0] res_vec;

   // The oldest token marks the cycle in which every column of one vector is aligned.
   assign res_valid = tok_q[TD-1];

   // Next-state, counters and registered-output values, all derived from the next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      res_cnt_d = res_valid ? res_cnt_q + ONE : res_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_W_FEED;
               cnt_d     = '0;
               n_d       = bus.cfg_n_vec;
               res_cnt_d = '0;
            end
         end
         S_W_FEED: begin
            if (cnt_q == W_LAST) begin
               state_d = S_W_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_W_SETTLE: begin
            // ROWS+1 quiet cycles let the last weight token reach the bottom row
            if (cnt_q == SETTLE_LAST) begin
               state_d = (n_q != '0) ? S_I_STREAM : S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_I_STREAM: begin
            if (cnt_q == n_q - ONE) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_DRAIN: begin
            if (res_valid && (res_cnt_q == n_q - ONE)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      w_rd_en_d     = (state_d == S_W_FEED);
      w_rd_addr_d   = w_rd_en_d ? AW'(ROWS - 1) - cnt_d[AW-1:0] : '0;
      img_rd_en_d   = (state_d == S_I_STREAM);
      img_rd_addr_d = img_rd_en_d ? cnt_d : '0;
      // loads line up with the buffer's one-cycle read latency
      arr_w_load_d  = {COLS{w_rd_en_q}};
      i_vld_d       = img_rd_en_q;
      tok_d         = {tok_q[TD-2:0], i_vld_q};
   end

   // FSM and control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         n_q           <= '0;
         res_cnt_q     <= '0;
         img_rd_addr_q <= '0;
         w_rd_addr_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         w_rd_en_q     <= 1'b0;
         img_rd_en_q   <= 1'b0;
         i_vld_q       <= 1'b0;
         arr_w_load_q  <= '0;
         tok_q         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         n_q           <= n_d;
         res_cnt_q     <= res_cnt_d;
         img_rd_addr_q <= img_rd_addr_d;
         w_rd_addr_q   <= w_rd_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         w_rd_en_q     <= w_rd_en_d;
         img_rd_en_q   <= img_rd_en_d;
         i_vld_q       <= i_vld_d;
         arr_w_load_q  <= arr_w_load_d;
         tok_q         <= tok_d;
      end
   end

   // Row skew: lane r is delayed r cycles, load bit travelling with its data.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [DL-1:0] lane_in;
      assign lane_in = i_vld_q ? bus.img_rd_data[r*DL +: DL] : '0;
      if (r == 0) begin : g_direct
         assign i_ld[r]  = i_vld_q;
         assign i_dat[r] = lane_in;
      end else begin : g_pipe
         logic [r-1:0]  ld_q, ld_d;
         logic [DL-1:0] dat_q [r];
         logic [DL-1:0] dat_d [r];
         // shift the lane one stage per cycle
         always_comb begin
            ld_d[0]  = i_vld_q;
            dat_d[0] = lane_in;
            for (int s = 1; s < r; s++) begin
               ld_d[s]  = ld_q[s-1];
               dat_d[s] = dat_q[s-1];
            end
         end
         // skew stages clear on reset so no stale image token survives
         always_ff @(posedge clk) begin
            if (rst) begin
               ld_q <= '0;
               for (int s = 0; s < r; s++) dat_q[s] <= '0;
            end else begin
               ld_q  <= ld_d;
               dat_q <= dat_d;
            end
         end
         assign i_ld[r]  = ld_q[r-1];
         assign i_dat[r] = dat_q[r-1];
      end
   end

   // Deskew: column c leaves the array c cycles late, so it is held COLS-1-c more.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int DC = COLS - 1 - c;
      if (DC == 0) begin : g_direct
         assign col_al[c] = bus.arr_acc[c*AL +: AL];
      end else begin : g_pipe
         logic [AL-1:0] acc_q [DC];
         logic [AL-1:0] acc_d [DC];
         // shift the column one stage per cycle
         always_comb begin
            acc_d[0] = bus.arr_acc[c*AL +: AL];
            for (int s = 1; s < DC; s++) acc_d[s] = acc_q[s-1];
         end
         // deskew stages clear on reset
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < DC; s++) acc_q[s] <= '0;
            end else begin
               acc_q <= acc_d;
            end
         end
         assign col_al[c] = acc_q[DC-1];
      end
   end

   // Pack per-lane and per-column signals into the flat buses.
   always_comb begin
      i_load_vec = '0;
      i_dat_vec  = '0;
      res_vec    = '0;
      for (int r = 0; r < ROWS; r++) begin
         i_load_vec[r]         = i_ld[r];
         i_dat_vec[r*DL +: DL] = i_dat[r];
      end
      for (int c = 0; c < COLS; c++) res_vec[c*AL +: AL] = col_al[c];
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.w_rd_en     = w_rd_en_q;
   assign bus.w_rd_addr   = w_rd_addr_q;
   assign bus.img_rd_en   = img_rd_en_q;
   assign bus.img_rd_addr = img_rd_addr_q;
   assign bus.arr_w_load  = arr_w_load_q;
   // data buses read zero whenever their load is idle, including straight after reset
   assign bus.arr_w_data  = (|arr_w_load_q) ? bus.w_rd_data : '0;
   assign bus.arr_i_load  = i_load_vec;
   assign bus.arr_i_data  = i_dat_vec;
   assign bus.res_valid   = res_valid;
   assign bus.res_data    = res_valid ? res_vec : '0;
   assign bus.res_idx     = res_cnt_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: random tiles and jobs against a cycle-timing reference model.
// Model predicts every output per cycle from job start cycle and N.
// Emulates the buffers (1-cycle read) and the MAU grid bottom row (dot products).
module tb_systolic_ctrl;
   localparam int ROWS = 4, COLS = 4, DL = 8, AL = 32, NV_W = 16;
   localparam int T0   = 2*ROWS + 2;
   localparam int NMAX = 64;
   localparam int WW   = COLS*DL;
   localparam int IW   = ROWS*DL;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .data_length(DL), .acc_length(AL), .NV_W(NV_W)) bus ();
   systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .data_length(DL), .acc_length(AL), .NV_W(NV_W)) dut (
      .clk(clk), .rst(rst), .bus(bus.master)
   );

   int n_vec = 0, n_err = 0, cyc = 0;
   logic [WW-1:0] wmem [ROWS];
   logic [IW-1:0] imem [NMAX];

   bit job_act = 0, chk_on = 0, prev_done = 0, pw_en = 0, pi_en = 0;
   int js = 0, jn = 0, pw_addr = 0, pi_addr = 0;

   function automatic int job_len(int n);
      return (n == 0) ? 2*ROWS + 2 : 3*ROWS + COLS + 2 + n;
   endfunction

   function automatic bit model_idle();
      return !job_act || (cyc - js) > job_len(jn);
   endfunction

   function automatic logic [AL-1:0] dotp(int k, int c);
      int acc, a, b;
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
         a = $signed(imem[k][r*DL +: DL]);
         b = $signed(wmem[r][c*DL +: DL]);
         acc += a * b;
      end
      return AL'(acc);
   endfunction

   task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic tick();
      int rel, d, k, kv;
      bit a, ewen, ewld, eien, erv;
      logic [ROWS-1:0]    eil;
      logic [IW-1:0]      eid;
      logic [COLS*AL-1:0] acc, erd;
      @(posedge clk);
      if (rst) begin
         job_act = 0;
         chk_on  = 1;
      end else if (bus.start && model_idle()) begin
         job_act = 1;
         js      = cyc;
         jn      = int'(bus.cfg_n_vec);
      end
      cyc++;
      #1;
      rel = cyc - js;
      a   = job_act;
      d   = job_len(jn);
      bus.w_rd_data   = pw_en ? wmem[pw_addr] : WW'($urandom);
      bus.img_rd_data = (pi_en && pi_addr < NMAX) ? imem[pi_addr] : IW'($urandom);
      for (int c = 0; c < COLS; c++) begin
         k = rel - T0 - 1 - ROWS - c;
         acc[c*AL +: AL] = (a && k >= 0 && k < jn) ? dotp(k, c) : AL'($urandom);
      end
      bus.arr_acc = acc;
      #1;
      if (chk_on) begin
         ewen = a && rel >= 1 && rel <= ROWS;
         ewld = a && rel >= 2 && rel <= ROWS + 1;
         eien = a && rel >= T0 && rel < T0 + jn;
         kv   = rel - T0 - ROWS - COLS;
         erv  = a && kv >= 0 && kv < jn;
         eil  = '0;
         eid  = '0;
         erd  = '0;
         for (int r = 0; r < ROWS; r++) begin
            k = rel - T0 - 1 - r;
            if (a && k >= 0 && k < jn) begin
               eil[r] = 1'b1;
               eid[r*DL +: DL] = imem[k][r*DL +: DL];
            end
         end
         if (erv) for (int c = 0; c < COLS; c++) erd[c*AL +: AL] = dotp(kv, c);
         chk("busy",       bus.busy,       a && rel >= 1 && rel <= d);
         chk("done",       bus.done,       a && rel == d);
         chk("w_rd_en",    bus.w_rd_en,    ewen);
         chk("w_rd_addr",  bus.w_rd_addr,  ewen ? ROWS - rel : 0);
         chk("arr_w_load", bus.arr_w_load, ewld ? {COLS{1'b1}} : '0);
         chk("arr_w_data", bus.arr_w_data, ewld ? wmem[ROWS + 1 - rel] : '0);
         chk("img_rd_en",  bus.img_rd_en,  eien);
         chk("img_rd_addr",bus.img_rd_addr,eien ? rel - T0 : 0);
         chk("arr_i_load", bus.arr_i_load, eil);
         chk("arr_i_data", bus.arr_i_data, eid);
         chk("res_valid",  bus.res_valid,  erv);
         chk("res_data",   bus.res_data,   erd);
         chk("res_idx",    bus.res_idx,    !a ? 0 : (kv < 0 ? 0 : (kv > jn ? jn : kv)));
         chk("w_i_excl",   (|bus.arr_w_load) && (|bus.arr_i_load), 1'b0);
         chk("done_pulse", bus.done && prev_done, 1'b0);
      end
      prev_done = (bus.done === 1'b1);
      pw_en     = (bus.w_rd_en === 1'b1);
      pw_addr   = int'(bus.w_rd_addr);
      pi_en     = (bus.img_rd_en === 1'b1);
      pi_addr   = int'(bus.img_rd_addr);
   endtask

   task automatic run_job(int n);
      bus.cfg_n_vec = NV_W'(n);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.cfg_n_vec = NV_W'($urandom);
      repeat (job_len(n) + 2) tick();
   endtask

   task automatic rand_tile();
      for (int r = 0; r < ROWS; r++) wmem[r] = WW'($urandom);
      for (int k = 0; k < NMAX; k++) imem[k] = IW'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.cfg_n_vec = '0;
      bus.w_rd_data = '0;
      bus.img_rd_data = '0;
      bus.arr_acc = '0;
      rand_tile();
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // identity weights: results equal the image elements, sign-extended
      for (int r = 0; r < ROWS; r++) begin
         wmem[r] = '0;
         wmem[r][r*DL +: DL] = 8'd1;
      end
      imem[0] = {8'd4, 8'd3, 8'd2, 8'd1};
      imem[1] = {8'd7, 8'd0, 8'd5, 8'hFF};
      run_job(3);

      // empty job
      run_job(0);

      // start held high through two back-to-back jobs
      rand_tile();
      n = 4;
      bus.cfg_n_vec = NV_W'(n);
      bus.start = 1'b1;
      repeat (job_len(n) + 2) tick();
      bus.start = 1'b0;
      repeat (job_len(n) + 2) tick();

      // random jobs with random gaps
      for (int j = 0; j < 8; j++) begin
         rand_tile();
         run_job($urandom_range(1, 24));
         repeat ($urandom_range(0, 3)) tick();
      end

      // reset during the image stream
      rand_tile();
      bus.cfg_n_vec = NV_W'(5);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (30) tick();

      // recovery after the aborted job
      rand_tile();
      run_job(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
